imem_loader: RTL

//   Byte-stream writer for the instruction memory that the fetch stage reads.
//   - Takes a word count and a byte stream over a valid/ready handshake.
//   - Assembles the bytes into 32-bit little-endian words and writes them to

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: loads the instruction memory from a byte stream.
//   A load starts in IDLE with start=1 and a word count. Bytes arrive over a
//   valid/ready handshake and are packed little-endian into 32-bit words.
//   Each word is written to the next word index, starting at 0. The stream
//   ends with one XOR checksum byte, which is checked against all data bytes.
//   busy holds the fetch/PC logic in reset while a load is in progress.
// Ports:
//   clk, reset         rising-edge clock; synchronous active-low reset
//   start, word_count  begin a load (sampled only in IDLE); word count
//   byte_in/valid      stream byte and its valid strobe
//   byte_ready         loader accepts a byte (LOAD and CHECK states)
//   mem_we/waddr/wdata one-cycle write to instruction memory; addr/data hold
//   busy               load in progress
//   done, err          sticky completion and failure flags; cleared by start
module imem_loader #(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW:0]   word_count,
   input  logic [7:0]    byte_in,
   input  logic          byte_valid,
   output logic          byte_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [31:0]   mem_wdata,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   state_t        state;
   state_t        state_nx;
   logic [AW:0]   count;
   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic [7:0]    xacc;
   logic [23:0]   wbuf;
   logic          xfer;
   logic          last_word;

   assign xfer      = byte_valid & byte_ready;
   assign last_word = ({1'b0, idx} == (count - (AW+1)'(1)));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (word_count > DEPTH_W)
                  state_nx = IDLE;
               else if (word_count == '0)
                  state_nx = CHECK;
               else
                  state_nx = LOAD;
            end
         end
         LOAD: begin
            if (xfer && (lane == 2'd3) && last_word)
               state_nx = CHECK;
         end
         CHECK: begin
            if (xfer)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         mem_waddr  <= '0;
         mem_wdata  <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         count      <= '0;
         idx        <= '0;
         lane       <= '0;
         xacc       <= '0;
         wbuf       <= '0;
      end else begin
         state <= state_nx;
         // busy and byte_ready follow the next state so both are plain flops
         // that always agree with the registered state.
         busy       <= (state_nx != IDLE);
         byte_ready <= (state_nx != IDLE);
         mem_we     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (word_count > DEPTH_W) begin
                     done <= 1'b1;
                     err  <= 1'b1;
                  end else begin
                     done  <= 1'b0;
                     err   <= 1'b0;
                     count <= word_count;
                     idx   <= '0;
                     lane  <= '0;
                     xacc  <= '0;
                  end
               end
            end
            LOAD: begin
               if (xfer) begin
                  xacc <= xacc ^ byte_in;
                  lane <= lane + 2'd1;
                  if (lane == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_waddr <= idx;
                     mem_wdata <= {byte_in, wbuf};
                     // Index stays on the final word so it never wraps.
                     if (!last_word)
                        idx <= idx + AW'(1);
                  end else begin
                     wbuf[lane*8 +: 8] <= byte_in;
                  end
               end
            end
            CHECK: begin
               if (xfer) begin
                  done <= 1'b1;
                  err  <= (byte_in != xacc);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
